// File: rtl/lcd_pkg.sv
// rtl/lcd_pkg.sv - shared constants, config record and helpers for the LCD layer scheduler
package lcd_pkg;

    localparam logic [15:0] RGB_BLACK = 16'h0000;
    localparam logic [15:0] RGB_WHITE = 16'hFFFF;
    localparam logic [15:0] RGB_RED   = 16'hF800;
    localparam logic [15:0] RGB_GREEN = 16'h07E0;
    localparam logic [15:0] RGB_BLUE  = 16'h001F;

    localparam logic [2:0] CFG_ADDR_CX = 3'd0;
    localparam logic [2:0] CFG_ADDR_CY = 3'd1;
    localparam logic [2:0] CFG_ADDR_R  = 3'd2;
    localparam logic [2:0] CFG_ADDR_FG = 3'd3;
    localparam logic [2:0] CFG_ADDR_BG = 3'd4;
    localparam logic [2:0] CFG_ADDR_EN = 3'd5;

    localparam int EN_GRID   = 0;
    localparam int EN_CIRCLE = 1;
    localparam int EN_TRACE  = 2;

    localparam int PIPE_LAT = 3;

    typedef struct packed {
        logic [10:0] cx;
        logic [10:0] cy;
        logic [9:0]  r;
        logic [15:0] fg;
        logic [15:0] bg;
        logic [2:0]  en;
    } lcd_cfg_t;

    // Addresses 6 and 7 are unmapped and must not disturb the bank.
    function automatic logic cfg_addr_valid(input logic [2:0] addr);
        return addr <= CFG_ADDR_EN;
    endfunction

endpackage

// File: rtl/lcd_cfg_shadow.sv
// rtl/lcd_cfg_shadow.sv - shadow/active config bank committed on the vblank rising edge
module lcd_cfg_shadow
    import lcd_pkg::*;
#(
    parameter lcd_cfg_t RST_CFG = '0
) (
    input  logic        lcd_clk,
    input  logic        sys_rst_n,
    input  logic        vblank_i,
    input  logic        cfg_wr_i,
    input  logic [2:0]  cfg_addr_i,
    input  logic [15:0] cfg_wdata_i,
    output lcd_cfg_t    act_cfg_o,
    output logic        cfg_pending_o
);

    lcd_cfg_t shadow_q, shadow_d;
    lcd_cfg_t active_q;
    logic     vblank_q;
    logic     pending_q, pending_d;
    logic     wr_valid;
    logic     commit;

    assign wr_valid = cfg_wr_i && cfg_addr_valid(cfg_addr_i);
    // Commit samples the shadow before this cycle's write lands, so a racing write stays pending.
    assign commit   = vblank_i && !vblank_q && pending_q;

    // Next shadow contents and pending flag from the write strobe and commit.
    always_comb begin
        shadow_d  = shadow_q;
        pending_d = pending_q;
        if (commit) begin
            pending_d = 1'b0;
        end
        if (cfg_wr_i) begin
            case (cfg_addr_i)
                CFG_ADDR_CX: shadow_d.cx = cfg_wdata_i[10:0];
                CFG_ADDR_CY: shadow_d.cy = cfg_wdata_i[10:0];
                CFG_ADDR_R:  shadow_d.r  = cfg_wdata_i[9:0];
                CFG_ADDR_FG: shadow_d.fg = cfg_wdata_i;
                CFG_ADDR_BG: shadow_d.bg = cfg_wdata_i;
                CFG_ADDR_EN: shadow_d.en = cfg_wdata_i[2:0];
                default:     ;
            endcase
        end
        if (wr_valid) begin
            pending_d = 1'b1;
        end
    end

    // Register bank, vblank edge history and the single-cycle shadow-to-active copy.
    always_ff @(posedge lcd_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            shadow_q  <= RST_CFG;
            active_q  <= RST_CFG;
            vblank_q  <= 1'b0;
            pending_q <= 1'b0;
        end else begin
            shadow_q  <= shadow_d;
            vblank_q  <= vblank_i;
            pending_q <= pending_d;
            if (commit) begin
                active_q <= shadow_q;
            end
        end
    end

    assign act_cfg_o     = active_q;
    assign cfg_pending_o = pending_q;

endmodule

// File: rtl/lcd_layer_ctrl.sv
// rtl/lcd_layer_ctrl.sv - three-stage per-pixel layer scheduler with fixed-priority mux
module lcd_layer_ctrl
    import lcd_pkg::*;
#(
    parameter logic [10:0] H_VALID = 11'd800,
    parameter logic [10:0] V_VALID = 11'd480,
    parameter logic [9:0]  DEF_R   = 10'd50,
    parameter logic [15:0] DEF_FG  = 16'hFFFF,
    parameter logic [15:0] DEF_BG  = 16'h0000
) (
    input  logic        lcd_clk,
    input  logic        sys_rst_n,
    input  logic        lcd_de,
    input  logic        vblank,
    input  logic [10:0] x,
    input  logic [10:0] y,
    input  logic        trace_hit,
    input  logic [15:0] trace_color,
    input  logic        grid_hit,
    input  logic [15:0] grid_color,
    input  logic        cfg_wr,
    input  logic [2:0]  cfg_addr,
    input  logic [15:0] cfg_wdata,
    output logic        cfg_pending,
    output logic        de_out,
    output logic [15:0] pixel
);

    localparam lcd_cfg_t RST_CFG = '{
        cx: H_VALID >> 2,
        cy: V_VALID >> 2,
        r:  DEF_R,
        fg: DEF_FG,
        bg: DEF_BG,
        en: 3'b111
    };

    lcd_cfg_t act_cfg;

    lcd_cfg_shadow #(
        .RST_CFG (RST_CFG)
    ) u_cfg_shadow (
        .lcd_clk       (lcd_clk),
        .sys_rst_n     (sys_rst_n),
        .vblank_i      (vblank),
        .cfg_wr_i      (cfg_wr),
        .cfg_addr_i    (cfg_addr),
        .cfg_wdata_i   (cfg_wdata),
        .act_cfg_o     (act_cfg),
        .cfg_pending_o (cfg_pending)
    );

    // Stage 1 state: centre offsets plus the side-band signals travelling with the pixel.
    logic signed [11:0] dx1_q, dy1_q;
    logic               de1_q, th1_q, gh1_q;
    logic [15:0]        tc1_q, gc1_q;
    // Stage 2 state: squared distance and squared radius.
    logic [23:0]        sq2_q;
    logic [19:0]        r2_2_q;
    logic               de2_q, th2_q, gh2_q;
    logic [15:0]        tc2_q, gc2_q;
    // Stage 3 state: the registered outputs.
    logic               de3_q;
    logic [15:0]        pixel_q;

    logic signed [11:0] dx_d, dy_d;
    logic signed [23:0] dx_w, dy_w;
    logic [23:0]        sq_d;
    logic [19:0]        r2_d;
    logic               in_circ;
    logic [15:0]        pixel_d;

    // Per-stage arithmetic and the priority mux feeding the output register.
    always_comb begin
        dx_d    = $signed({1'b0, x}) - $signed({1'b0, act_cfg.cx});
        dy_d    = $signed({1'b0, y}) - $signed({1'b0, act_cfg.cy});
        dx_w    = 24'(dx1_q);
        dy_w    = 24'(dy1_q);
        sq_d    = dx_w * dx_w + dy_w * dy_w;
        r2_d    = {10'd0, act_cfg.r} * {10'd0, act_cfg.r};
        in_circ = sq2_q <= {4'd0, r2_2_q};
        pixel_d = act_cfg.bg;
        if (!de2_q) begin
            pixel_d = RGB_BLACK;
        end else if (act_cfg.en[EN_TRACE] && th2_q) begin
            pixel_d = tc2_q;
        end else if (act_cfg.en[EN_CIRCLE] && in_circ) begin
            pixel_d = act_cfg.fg;
        end else if (act_cfg.en[EN_GRID] && gh2_q) begin
            pixel_d = gc2_q;
        end
    end

    // Fixed three-deep pixel pipeline; every stage advances every cycle so de may toggle freely.
    always_ff @(posedge lcd_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            dx1_q   <= '0;
            dy1_q   <= '0;
            de1_q   <= 1'b0;
            th1_q   <= 1'b0;
            gh1_q   <= 1'b0;
            tc1_q   <= '0;
            gc1_q   <= '0;
            sq2_q   <= '0;
            r2_2_q  <= '0;
            de2_q   <= 1'b0;
            th2_q   <= 1'b0;
            gh2_q   <= 1'b0;
            tc2_q   <= '0;
            gc2_q   <= '0;
            de3_q   <= 1'b0;
            pixel_q <= '0;
        end else begin
            dx1_q   <= dx_d;
            dy1_q   <= dy_d;
            de1_q   <= lcd_de;
            th1_q   <= trace_hit;
            gh1_q   <= grid_hit;
            tc1_q   <= trace_color;
            gc1_q   <= grid_color;
            sq2_q   <= sq_d;
            r2_2_q  <= r2_d;
            de2_q   <= de1_q;
            th2_q   <= th1_q;
            gh2_q   <= gh1_q;
            tc2_q   <= tc1_q;
            gc2_q   <= gc1_q;
            de3_q   <= de2_q;
            pixel_q <= pixel_d;
        end
    end

    assign de_out = de3_q;
    assign pixel  = pixel_q;

endmodule

// File: tb/tb_lcd_layer_ctrl.sv
// tb/tb_lcd_layer_ctrl.sv - self-checking bench for lcd_layer_ctrl
module tb_lcd_layer_ctrl;

    localparam int H_VALID = 800;
    localparam int V_VALID = 480;

    logic        lcd_clk     = 1'b0;
    logic        sys_rst_n   = 1'b0;
    logic        lcd_de      = 1'b0;
    logic        vblank      = 1'b0;
    logic [10:0] x           = '0;
    logic [10:0] y           = '0;
    logic        trace_hit   = 1'b0;
    logic [15:0] trace_color = '0;
    logic        grid_hit    = 1'b0;
    logic [15:0] grid_color  = '0;
    logic        cfg_wr      = 1'b0;
    logic [2:0]  cfg_addr    = '0;
    logic [15:0] cfg_wdata   = '0;
    logic        cfg_pending;
    logic        de_out;
    logic [15:0] pixel;

    lcd_layer_ctrl dut (
        .lcd_clk     (lcd_clk),
        .sys_rst_n   (sys_rst_n),
        .lcd_de      (lcd_de),
        .vblank      (vblank),
        .x           (x),
        .y           (y),
        .trace_hit   (trace_hit),
        .trace_color (trace_color),
        .grid_hit    (grid_hit),
        .grid_color  (grid_color),
        .cfg_wr      (cfg_wr),
        .cfg_addr    (cfg_addr),
        .cfg_wdata   (cfg_wdata),
        .cfg_pending (cfg_pending),
        .de_out      (de_out),
        .pixel       (pixel)
    );

    always #5 lcd_clk = ~lcd_clk;

    int checks   = 0;
    int failures = 0;
    bit running  = 1'b1;

    // Reference model state: active and shadow configuration as plain integers.
    int          a_cx, a_cy, a_r, s_cx, s_cy, s_r;
    logic [15:0] a_fg, a_bg, s_fg, s_bg;
    logic [2:0]  a_en, s_en;
    bit          m_pending, m_prev_vb;
    bit          exp_de [3];
    logic [15:0] exp_px [3];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        a_cx = H_VALID / 4; a_cy = V_VALID / 4; a_r = 50;
        a_fg = 16'hFFFF; a_bg = 16'h0000; a_en = 3'b111;
        s_cx = a_cx; s_cy = a_cy; s_r = a_r;
        s_fg = a_fg; s_bg = a_bg; s_en = a_en;
        m_pending = 1'b0;
        m_prev_vb = 1'b0;
        for (int i = 0; i < 3; i++) begin
            exp_de[i] = 1'b0;
            exp_px[i] = 16'h0000;
        end
    endtask

    function automatic logic [15:0] model_pix(input int px, input int py);
        int dx, dy;
        dx = px - a_cx;
        dy = py - a_cy;
        if (a_en[2] && trace_hit) return trace_color;
        if (a_en[1] && (dx * dx + dy * dy <= a_r * a_r)) return a_fg;
        if (a_en[0] && grid_hit) return grid_color;
        return a_bg;
    endfunction

    task automatic model_step();
        logic [15:0] p;
        bit          commit;
        p = lcd_de ? model_pix(int'(x), int'(y)) : 16'h0000;
        for (int i = 2; i > 0; i--) begin
            exp_de[i] = exp_de[i-1];
            exp_px[i] = exp_px[i-1];
        end
        exp_de[0] = lcd_de;
        exp_px[0] = p;
        commit = vblank && !m_prev_vb && m_pending;
        if (commit) begin
            a_cx = s_cx; a_cy = s_cy; a_r = s_r;
            a_fg = s_fg; a_bg = s_bg; a_en = s_en;
            m_pending = 1'b0;
        end
        m_prev_vb = vblank;
        if (cfg_wr && int'(cfg_addr) <= 5) begin
            case (int'(cfg_addr))
                0: s_cx = int'(cfg_wdata[10:0]);
                1: s_cy = int'(cfg_wdata[10:0]);
                2: s_r  = int'(cfg_wdata[9:0]);
                3: s_fg = cfg_wdata;
                4: s_bg = cfg_wdata;
                default: s_en = cfg_wdata[2:0];
            endcase
            m_pending = 1'b1;
        end
    endtask

    // Model advances on every clock edge and on asynchronous reset.
    initial begin
        model_reset();
        forever begin
            @(posedge lcd_clk or negedge sys_rst_n);
            if (!sys_rst_n) model_reset();
            else model_step();
        end
    end

    // Continuous comparison of all outputs against the model, away from the active edge.
    initial begin
        forever begin
            @(negedge lcd_clk);
            if (running) begin
                chk("pipe_pixel", 32'(pixel), 32'(exp_px[2]));
                chk("pipe_de_out", 32'(de_out), 32'(exp_de[2]));
                chk("pipe_cfg_pending", 32'(cfg_pending), 32'(m_pending));
            end
        end
    end

    task automatic probe(input int px, input int py, input bit th, input logic [15:0] tc,
                         input bit gh, input logic [15:0] gc, input logic [15:0] exp,
                         input string name);
        @(negedge lcd_clk);
        lcd_de = 1'b1; x = 11'(px); y = 11'(py);
        trace_hit = th; trace_color = tc; grid_hit = gh; grid_color = gc;
        @(negedge lcd_clk);
        lcd_de = 1'b0; trace_hit = 1'b0; grid_hit = 1'b0;
        repeat (2) @(negedge lcd_clk);
        chk(name, 32'(pixel), 32'(exp));
        chk({name, "_de"}, 32'(de_out), 32'd1);
    endtask

    task automatic px_plain(input int px, input int py, input logic [15:0] exp, input string name);
        probe(px, py, 1'b0, 16'h0, 1'b0, 16'h0, exp, name);
    endtask

    task automatic cfg_write(input logic [2:0] addr, input logic [15:0] data);
        @(negedge lcd_clk);
        cfg_wr = 1'b1; cfg_addr = addr; cfg_wdata = data;
        @(negedge lcd_clk);
        cfg_wr = 1'b0;
    endtask

    task automatic commit_frame();
        @(negedge lcd_clk);
        vblank = 1'b1;
        repeat (3) @(negedge lcd_clk);
        vblank = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (3) @(negedge lcd_clk);
        chk("rst_pixel", 32'(pixel), 32'h0);
        chk("rst_de_out", 32'(de_out), 32'h0);
        chk("rst_pending", 32'(cfg_pending), 32'h0);
        sys_rst_n = 1'b1;

        // Default circle centred at (200,120), radius 50
        px_plain(200, 120, 16'hFFFF, "t1_centre");
        px_plain(0, 0, 16'h0000, "t1_origin");

        // Radius boundary
        px_plain(250, 120, 16'hFFFF, "t2_edge_in");
        px_plain(251, 120, 16'h0000, "t2_edge_out");
        px_plain(235, 155, 16'hFFFF, "t2_diag_in");
        px_plain(236, 156, 16'h0000, "t2_diag_out");

        // Layer priority
        probe(200, 120, 1'b1, 16'h07E0, 1'b1, 16'h001F, 16'h07E0, "t3_trace_top");
        cfg_write(3'd5, 16'h0003);
        commit_frame();
        probe(200, 120, 1'b1, 16'h07E0, 1'b1, 16'h001F, 16'hFFFF, "t3_circle_top");
        cfg_write(3'd5, 16'h0001);
        commit_frame();
        probe(200, 120, 1'b1, 16'h07E0, 1'b1, 16'h001F, 16'h001F, "t3_grid_only");
        cfg_write(3'd5, 16'h0007);
        commit_frame();

        // Unmapped address
        cfg_write(3'd7, 16'h1234);
        chk("t5_pending", 32'(cfg_pending), 32'h0);
        px_plain(200, 120, 16'hFFFF, "t5_centre");
        px_plain(251, 120, 16'h0000, "t5_edge_out");

        // Shadow radius held until vblank
        cfg_write(3'd2, 16'd10);
        chk("t4_pending_set", 32'(cfg_pending), 32'h1);
        px_plain(250, 120, 16'hFFFF, "t4_old_radius");
        commit_frame();
        chk("t4_pending_clr", 32'(cfg_pending), 32'h0);
        px_plain(250, 120, 16'h0000, "t4_new_radius_out");
        px_plain(210, 120, 16'hFFFF, "t4_new_radius_in");
        cfg_write(3'd2, 16'd50);
        // Write racing the commit edge
        @(negedge lcd_clk);
        vblank = 1'b1; cfg_wr = 1'b1; cfg_addr = 3'd3; cfg_wdata = 16'hF800;
        @(negedge lcd_clk);
        cfg_wr = 1'b0;
        chk("t4_race_pending", 32'(cfg_pending), 32'h1);
        repeat (2) @(negedge lcd_clk);
        vblank = 1'b0;
        px_plain(250, 120, 16'hFFFF, "t4_race_old_fg");
        commit_frame();
        chk("t4_race_commit", 32'(cfg_pending), 32'h0);
        px_plain(200, 120, 16'hF800, "t4_race_new_fg");

        // Centre beyond the right edge of the screen
        cfg_write(3'd0, 16'd820);
        commit_frame();
        px_plain(799, 120, 16'hF800, "bnd_offscreen_in");
        px_plain(769, 120, 16'h0000, "bnd_offscreen_out");

        // Zero radius
        cfg_write(3'd0, 16'd200);
        cfg_write(3'd2, 16'd0);
        commit_frame();
        px_plain(200, 120, 16'hF800, "bnd_r0_centre");
        px_plain(201, 120, 16'h0000, "bnd_r0_right");
        px_plain(200, 121, 16'h0000, "bnd_r0_below");

        // de toggling every cycle, then a solid run
        for (int i = 0; i < 12; i++) begin
            @(negedge lcd_clk);
            lcd_de = i[0]; x = 11'(195 + i); y = 11'd120;
            trace_hit = (i % 5 == 0); trace_color = 16'h07E0;
            grid_hit = (i % 3 == 0); grid_color = 16'h001F;
        end
        for (int i = 0; i < 8; i++) begin
            @(negedge lcd_clk);
            lcd_de = 1'b1; x = 11'(196 + i); y = 11'd120;
            trace_hit = 1'b0; grid_hit = (i % 2 == 1);
        end
        @(negedge lcd_clk);
        lcd_de = 1'b0; grid_hit = 1'b0;
        repeat (4) @(negedge lcd_clk);

        // Asynchronous reset mid-line
        lcd_de = 1'b1; x = 11'd200; y = 11'd120;
        repeat (4) @(negedge lcd_clk);
        #2 sys_rst_n = 1'b0;
        #1;
        chk("t6_rst_pixel", 32'(pixel), 32'h0);
        chk("t6_rst_de_out", 32'(de_out), 32'h0);
        @(negedge lcd_clk);
        chk("t6_rst_hold_pixel", 32'(pixel), 32'h0);
        @(negedge lcd_clk);
        sys_rst_n = 1'b1;
        lcd_de = 1'b0;
        px_plain(250, 120, 16'hFFFF, "t6_cfg_radius");
        px_plain(200, 120, 16'hFFFF, "t6_cfg_fg");
        px_plain(300, 120, 16'h0000, "t6_cfg_bg");

        repeat (4) @(negedge lcd_clk);
        running = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
